// File: rtl/softmax_pkg.sv
// Shared types and fixed-point helpers for the softmax forward/backward blocks.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOT  = 2'd1,
    OUT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int WIDTH_DEFAULT = 32;
  localparam logic signed [WIDTH_DEFAULT-1:0] SAT_MAX = {1'b0, {(WIDTH_DEFAULT-1){1'b1}}};
  localparam logic signed [WIDTH_DEFAULT-1:0] SAT_MIN = {1'b1, {(WIDTH_DEFAULT-1){1'b0}}};

  // Clamp a wide signed value into the signed range of a w-bit word (w <= 64).
  // Result is returned sign-correct in the low w bits of a 64-bit container.
  function automatic logic signed [63:0] sat_w(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi) return hi[63:0];
    if (v < lo) return lo[63:0];
    return v[63:0];
  endfunction

  // Fixed-point multiply: full product, arithmetic shift (floor), then saturate.
  function automatic logic signed [63:0] fxmul_w(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w, input int frac);
    logic signed [127:0] p;
    p = 128'(a) * 128'(b);
    p = p >>> frac;
    return sat_w(p, w);
  endfunction

endpackage

// File: rtl/softmax_backward_mul.sv
// Combinational saturating fixed-point multiplier shared by both passes.
module fixed_point_mul
  import softmax_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int FIXED_POINT_INDEX = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] full;
  logic signed [PW-1:0] shifted;
  logic signed [63:0]   clamped;

  // Full-width product, floor shift to the Q format, clamp to WIDTH bits
  always_comb begin
    full    = PW'(a) * PW'(b);
    shifted = full >>> FIXED_POINT_INDEX;
    clamped = sat_w(128'(shifted), WIDTH);
    product = clamped[WIDTH-1:0];
  end

endmodule

// File: rtl/softmax_backward.sv
// Softmax backward pass: dx[i] = y[i] * (g[i] - sum_j g[j]*y[j]),
// one shared multiplier stepped over a dot pass then an output pass.
module softmax_backward
  import softmax_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int DIMENSION         = 4,
  parameter int FIXED_POINT_INDEX = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] softmax_data [DIMENSION],
  input  logic signed [WIDTH-1:0] grad_data    [DIMENSION],
  output logic signed [WIDTH-1:0] output_data  [DIMENSION],
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIMENSION - 1);

  state_t state, state_next;

  logic signed [WIDTH-1:0] y_reg [DIMENSION];
  logic signed [WIDTH-1:0] g_reg [DIMENSION];
  logic signed [WIDTH-1:0] acc;
  logic [IW-1:0]           idx;
  logic                    last;

  logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;
  logic signed [WIDTH-1:0] acc_sum, g_minus_acc;
  logic signed [63:0]      wide_sum, wide_diff;

  assign last = (idx == LAST_IDX);

  // Saturating accumulate (dot pass) and saturating g - acc (output pass)
  always_comb begin
    wide_sum    = sat_w(128'(acc) + 128'(mul_p), WIDTH);
    wide_diff   = sat_w(128'(g_reg[idx]) - 128'(acc), WIDTH);
    acc_sum     = wide_sum[WIDTH-1:0];
    g_minus_acc = wide_diff[WIDTH-1:0];
  end

  // Operand select for the shared multiplier: g*y in DOT, y*(g-acc) in OUT
  always_comb begin
    mul_a = g_reg[idx];
    mul_b = y_reg[idx];
    if (state == OUT) begin
      mul_a = y_reg[idx];
      mul_b = g_minus_acc;
    end
  end

  fixed_point_mul #(
    .WIDTH            (WIDTH),
    .FIXED_POINT_INDEX(FIXED_POINT_INDEX)
  ) u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .product(mul_p)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = DOT;
      DOT: begin
        busy = 1'b1;
        if (last) state_next = OUT;
      end
      OUT: begin
        busy = 1'b1;
        if (last) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, accumulator, element index and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIMENSION; i++) begin
        y_reg[i]       <= '0;
        g_reg[i]       <= '0;
        output_data[i] <= '0;
      end
      acc <= '0;
      idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < DIMENSION; i++) begin
              y_reg[i] <= softmax_data[i];
              g_reg[i] <= grad_data[i];
            end
            acc <= '0;
            idx <= '0;
          end
        end
        DOT: begin
          acc <= acc_sum;
          idx <= last ? '0 : idx + 1'b1;
        end
        OUT: begin
          output_data[idx] <= mul_p;
          idx <= last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_backward.sv
// Self-checking bench for softmax_backward: table vectors, random vectors
// against a behavioural model, and handshake/reset corner sequences.
module tb_softmax_backward;

  localparam int W = 32;
  localparam int D = 4;

  typedef struct {
    logic signed [W-1:0] y [D];
    logic signed [W-1:0] g [D];
    logic signed [W-1:0] o [D];
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic signed [W-1:0] softmax_data [D];
  logic signed [W-1:0] grad_data    [D];
  logic signed [W-1:0] output_data  [D];
  logic busy, done;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int done_expected = 0;
  vec_t sb[$];
  vec_t tbl[4];

  softmax_backward #(.WIDTH(W), .DIMENSION(D), .FIXED_POINT_INDEX(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .softmax_data(softmax_data),
    .grad_data   (grad_data),
    .output_data (output_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference in 64-bit integer arithmetic
  function automatic logic signed [W-1:0] m_sat(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
    return v[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] m_mul(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    p = p >>> 16;
    return m_sat(p);
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic signed [W-1:0] acc;
    r = v;
    acc = '0;
    for (int i = 0; i < D; i++) acc = m_sat(longint'(acc) + longint'(m_mul(v.g[i], v.y[i])));
    for (int i = 0; i < D; i++) r.o[i] = m_mul(v.y[i], m_sat(longint'(v.g[i]) - longint'(acc)));
    return r;
  endfunction

  // Scoreboard: compare every element when done pulses
  always @(negedge clk) begin : mon
    vec_t e;
    if (!reset && done === 1'b1) begin
      done_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < D; i++) chk($sformatf("out[%0d]", i), output_data[i], e.o[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a vector and pulse start; returns in cycle 1 of the operation
  task automatic launch(input vec_t v);
    softmax_data = v.y;
    grad_data    = v.g;
    start        = 1'b1;
    sb.push_back(v);
    done_expected++;
    step();
    start = 1'b0;
  endtask

  // Count cycles until done, checking busy on the way and latency at the end
  task automatic wait_done(input int cyc0, input string name);
    int cyc;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 40) begin
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
      step();
      cyc++;
    end
    chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({name, "_latency"}, cyc, 32'd9);
    chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    step();
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v, alt;
    int r;

    tbl[0].y = '{32'h00004000, 32'h00004000, 32'h00004000, 32'h00004000};
    tbl[0].g = '{32'h00010000, 32'h0, 32'h0, 32'h0};
    tbl[0].o = '{32'h00003000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000};
    tbl[1].y = '{32'h00004000, 32'h00004000, 32'h00004000, 32'h00004000};
    tbl[1].g = '{32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000};
    tbl[1].o = '{32'h0, 32'h0, 32'h0, 32'h0};
    tbl[2].y = '{32'h00008000, 32'h00008000, 32'h0, 32'h0};
    tbl[2].g = '{32'h00010000, 32'hFFFF0000, 32'h00040000, 32'h00040000};
    tbl[2].o = '{32'h00008000, 32'hFFFF8000, 32'h0, 32'h0};
    tbl[3].y = '{32'h7FFF0000, 32'h0, 32'h0, 32'h0};
    tbl[3].g = '{32'h00020000, 32'h0, 32'h0, 32'h0};
    tbl[3].o = '{32'h80000000, 32'h0, 32'h0, 32'h0};

    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < D; i++) begin
      softmax_data[i] = '0;
      grad_data[i]    = '0;
    end
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < D; i++) chk($sformatf("rst_out[%0d]", i), output_data[i], 32'd0);
    reset = 1'b0;
    step();

    // Spec vectors
    for (int t = 0; t < 4; t++) begin
      launch(tbl[t]);
      wait_done(1, $sformatf("tbl%0d", t));
      step();
    end

    // Random vectors against the model
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < D; i++) begin
        v.y[i] = $urandom_range(0, 32'h00010000);
        r = $urandom_range(0, 32'h00080000);
        v.g[i] = r - 32'sh00040000;
      end
      v = model(v);
      launch(v);
      wait_done(1, $sformatf("rnd%0d", t));
    end

    // Start re-pulsed while busy with changed inputs: ignored
    launch(tbl[0]);
    step();
    step();
    alt = tbl[2];
    softmax_data = alt.y;
    grad_data    = alt.g;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(4, "restart_busy");
    repeat (12) step();

    // Start held high through busy and FIN: exactly one operation
    softmax_data = tbl[2].y;
    grad_data    = tbl[2].g;
    sb.push_back(tbl[2]);
    done_expected++;
    start = 1'b1;
    repeat (9) step();
    chk("held_done_cycle9", {31'd0, done}, 32'd1);
    start = 1'b0;
    repeat (12) step();

    // Reset in cycle 5 of an operation
    launch(tbl[0]);
    repeat (4) step();
    reset = 1'b1;
    #1;
    sb.delete();
    done_expected--;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < D; i++) chk($sformatf("abort_out[%0d]", i), output_data[i], 32'd0);
    step();
    reset = 1'b0;
    step();
    launch(tbl[3]);
    wait_done(1, "after_abort");
    repeat (12) step();

    chk("done_count", done_count, done_expected);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
